work_ram_arbiter: RTL and testbench

Shares the single-port main work RAM between the 3 MHz CPU bus and the hiscore save/restore interface. The CPU owns the RAM by default. On hiscore access the block freezes the CPU through the clock-generator pause input, waits a settle interval, then hands the RAM port to the hiscore interface until access ends. It sits beside MAIN in the top level and runs on the 48 MHz system clock, using CPU-cycle strobes rather than derived clocks.

---
 rtl/work_ram_arbiter.sv | 142 ++++++++++++++
 tb/tb_work_ram_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/work_ram_arbiter.sv
// work_ram_arbiter: shares the single-port main work RAM between the CPU bus
// and the hiscore save/restore port. The CPU owns the RAM by default. A hiscore
// request pauses the CPU, waits SETTLE clocks, then grants the RAM to hiscore.
module work_ram_arbiter #(
    parameter int AW     = 11,
    parameter int SETTLE = 32
) (
    input  logic          clk48M,
    input  logic          reset,
    input  logic          cpu_ce,
    input  logic          cpu_sel,
    input  logic [AW-1:0] cpu_ad,
    input  logic          cpu_wr,
    input  logic [7:0]    cpu_wd,
    output logic [7:0]    cpu_rd,
    input  logic          hs_access,
    input  logic          hs_write,
    input  logic [AW-1:0] hs_address,
    input  logic [7:0]    hs_data_in,
    output logic [7:0]    hs_data_out,
    output logic          hs_grant,
    output logic          pause_req,
    output logic          conflict,
    output logic [AW-1:0] ram_ad,
    output logic          ram_we,
    output logic [7:0]    ram_wd,
    input  logic [7:0]    ram_rd
);

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HS      = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

    state_t        state, state_nxt;
    logic [7:0]    cnt, cnt_nxt;
    logic [1:0]    rd_pend, rd_pend_nxt;
    logic          pause_nxt, grant_nxt, conflict_nxt, we_nxt;
    logic [AW-1:0] ad_nxt;
    logic [7:0]    wd_nxt, cpu_rd_nxt, hs_do_nxt;
    logic          cpu_hit;

    assign cpu_hit = cpu_ce & cpu_sel;

    // State and datapath registers; reset cancels any pending read capture.
    always_ff @(posedge clk48M or posedge reset) begin
        if (reset) begin
            state       <= ST_CPU;
            cnt         <= '0;
            rd_pend     <= '0;
            pause_req   <= 1'b0;
            hs_grant    <= 1'b0;
            conflict    <= 1'b0;
            ram_ad      <= '0;
            ram_we      <= 1'b0;
            ram_wd      <= '0;
            cpu_rd      <= '0;
            hs_data_out <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rd_pend     <= rd_pend_nxt;
            pause_req   <= pause_nxt;
            hs_grant    <= grant_nxt;
            conflict    <= conflict_nxt;
            ram_ad      <= ad_nxt;
            ram_we      <= we_nxt;
            ram_wd      <= wd_nxt;
            cpu_rd      <= cpu_rd_nxt;
            hs_data_out <= hs_do_nxt;
        end
    end

    // Next-state and next-output logic for the ownership FSM.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pause_nxt    = pause_req;
        grant_nxt    = hs_grant;
        conflict_nxt = conflict;
        ad_nxt       = ram_ad;
        we_nxt       = 1'b0;
        wd_nxt       = ram_wd;
        hs_do_nxt    = hs_data_out;
        // CPU read pipeline runs independently of the FSM so a read issued on
        // the edge that enters DRAIN still lands two clocks later.
        rd_pend_nxt  = {rd_pend[0], 1'b0};
        cpu_rd_nxt   = rd_pend[1] ? ram_rd : cpu_rd;

        unique case (state)
            ST_CPU: begin
                if (cpu_hit) begin
                    ad_nxt         = cpu_ad;
                    we_nxt         = cpu_wr;
                    wd_nxt         = cpu_wd;
                    rd_pend_nxt[0] = ~cpu_wr;
                end
                if (hs_access) begin
                    state_nxt = ST_DRAIN;
                    pause_nxt = 1'b1;
                    cnt_nxt   = SETTLE_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!hs_access) begin
                    state_nxt = ST_RELEASE;
                end else if (cnt == 8'd0) begin
                    state_nxt = ST_HS;
                    grant_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_HS: begin
                hs_do_nxt = ram_rd;
                if (cpu_hit) begin
                    conflict_nxt = 1'b1;
                end
                if (!hs_access) begin
                    state_nxt = ST_RELEASE;
                    grant_nxt = 1'b0;
                end else begin
                    ad_nxt = hs_address;
                    we_nxt = hs_write;
                    wd_nxt = hs_data_in;
                end
            end
            ST_RELEASE: begin
                pause_nxt = 1'b0;
                state_nxt = ST_CPU;
            end
            default: begin
                state_nxt = ST_CPU;
            end
        endcase
    end

endmodule

// File: tb/tb_work_ram_arbiter.sv
// Bench for work_ram_arbiter: directed stimulus pushes expectations into
// queues; a monitor on the falling edge checks RAM writes and timed outputs.
module tb_work_ram_arbiter;

    localparam int AW = 11;

    localparam int S_CPURD = 0;
    localparam int S_HSDO  = 1;
    localparam int S_GRANT = 2;
    localparam int S_PAUSE = 3;
    localparam int S_CONF  = 4;
    localparam int S_WE    = 5;
    localparam int S_AD    = 6;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } chk_t;

    typedef struct {
        logic [AW-1:0] ad;
        logic [7:0]    wd;
    } wr_t;

    logic          clk48M = 1'b0;
    logic          reset;
    logic          cpu_ce, cpu_sel, cpu_wr;
    logic [AW-1:0] cpu_ad;
    logic [7:0]    cpu_wd, cpu_rd;
    logic          hs_access, hs_write;
    logic [AW-1:0] hs_address;
    logic [7:0]    hs_data_in, hs_data_out;
    logic          hs_grant, pause_req, conflict;
    logic [AW-1:0] ram_ad;
    logic          ram_we;
    logic [7:0]    ram_wd, ram_rd;

    logic [7:0]    mem [0:(1<<AW)-1];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    chk_t          chkq[$];
    wr_t           wq[$];

    work_ram_arbiter #(.AW(AW), .SETTLE(32)) dut (
        .clk48M      (clk48M),
        .reset       (reset),
        .cpu_ce      (cpu_ce),
        .cpu_sel     (cpu_sel),
        .cpu_ad      (cpu_ad),
        .cpu_wr      (cpu_wr),
        .cpu_wd      (cpu_wd),
        .cpu_rd      (cpu_rd),
        .hs_access   (hs_access),
        .hs_write    (hs_write),
        .hs_address  (hs_address),
        .hs_data_in  (hs_data_in),
        .hs_data_out (hs_data_out),
        .hs_grant    (hs_grant),
        .pause_req   (pause_req),
        .conflict    (conflict),
        .ram_ad      (ram_ad),
        .ram_we      (ram_we),
        .ram_wd      (ram_wd),
        .ram_rd      (ram_rd)
    );

    always #10 clk48M = ~clk48M;

    always @(posedge clk48M) cyc <= cyc + 1;

    // Synchronous single-port RAM, read-before-write.
    always @(posedge clk48M) begin
        if (ram_we) mem[ram_ad] <= ram_wd;
        ram_rd <= mem[ram_ad];
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h required %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [31:0] sample(int sig);
        case (sig)
            S_CPURD: return 32'(cpu_rd);
            S_HSDO:  return 32'(hs_data_out);
            S_GRANT: return 32'(hs_grant);
            S_PAUSE: return 32'(pause_req);
            S_CONF:  return 32'(conflict);
            S_WE:    return 32'(ram_we);
            S_AD:    return 32'(ram_ad);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_at(int c, int sig, logic [31:0] v, string name);
        chk_t e;
        e.cyc = c; e.sig = sig; e.val = v; e.name = name;
        chkq.push_back(e);
    endtask

    task automatic push_write(logic [AW-1:0] ad, logic [7:0] wd);
        wr_t w;
        w.ad = ad; w.wd = wd;
        wq.push_back(w);
    endtask

    task automatic step();
        @(negedge clk48M);
    endtask

    // One CPU bus strobe followed by the idle clocks of a 16-clock bus cycle.
    task automatic cpu_access(logic sel, logic wr, logic [AW-1:0] ad,
                              logic [7:0] wd, logic [7:0] exp_rd);
        int t;
        cpu_ce = 1'b1; cpu_sel = sel; cpu_wr = wr; cpu_ad = ad; cpu_wd = wd;
        t = cyc + 1;
        if (sel && wr) begin
            push_write(ad, wd);
            expect_at(t, S_AD, 32'(ad), "cpu_wr_ad");
            expect_at(t + 1, S_WE, 0, "cpu_we_one_clock");
        end else if (!wr) begin
            expect_at(t + 2, S_CPURD, 32'(exp_rd), "cpu_rd");
        end
        step();
        cpu_ce = 1'b0; cpu_sel = 1'b0; cpu_wr = 1'b0;
        repeat (15) step();
    endtask

    // Monitor: RAM writes are consumed in order, timed checks by cycle.
    always @(negedge clk48M) begin
        wr_t w;
        if (ram_we === 1'b1) begin
            if (wq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ram_write @cyc %0d: got ad=%0h wd=%0h required no write",
                         cyc, ram_ad, ram_wd);
            end else begin
                w = wq.pop_front();
                check("ram_write_ad", 32'(ram_ad), 32'(w.ad));
                check("ram_write_wd", 32'(ram_wd), 32'(w.wd));
            end
        end
        for (int i = chkq.size() - 1; i >= 0; i--) begin
            if (chkq[i].cyc == cyc) begin
                check(chkq[i].name, sample(chkq[i].sig), chkq[i].val);
                chkq.delete(i);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e, g, r, a, w, k;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        reset = 1'b1;
        cpu_ce = 1'b0; cpu_sel = 1'b0; cpu_wr = 1'b0; cpu_ad = '0; cpu_wd = '0;
        hs_access = 1'b0; hs_write = 1'b0; hs_address = '0; hs_data_in = '0;

        // Reset values.
        repeat (3) step();
        expect_at(cyc + 1, S_PAUSE, 0, "rst_pause");
        expect_at(cyc + 1, S_GRANT, 0, "rst_grant");
        expect_at(cyc + 1, S_CONF,  0, "rst_conflict");
        expect_at(cyc + 1, S_WE,    0, "rst_we");
        expect_at(cyc + 1, S_CPURD, 0, "rst_cpu_rd");
        expect_at(cyc + 1, S_HSDO,  0, "rst_hs_do");
        expect_at(cyc + 1, S_AD,    0, "rst_ram_ad");
        step();
        reset = 1'b0;
        step();

        // CPU write then read back, plus an unselected strobe.
        cpu_access(1'b1, 1'b1, 11'h123, 8'hA5, 8'h00);
        cpu_access(1'b1, 1'b0, 11'h123, 8'h00, 8'hA5);
        cpu_access(1'b1, 1'b1, 11'h3FF, 8'h5A, 8'h00);
        cpu_access(1'b0, 1'b0, 11'h3FF, 8'h00, 8'hA5);
        cpu_access(1'b1, 1'b0, 11'h000, 8'h00, 8'h00);

        // Grant sequence with a CPU read issued on the same edge.
        hs_access = 1'b1;
        cpu_ce = 1'b1; cpu_sel = 1'b1; cpu_wr = 1'b0; cpu_ad = 11'h3FF;
        e = cyc + 1;
        expect_at(e,      S_PAUSE, 1, "grant_pause_rise");
        expect_at(e,      S_GRANT, 0, "grant_early0");
        expect_at(e + 2,  S_CPURD, 32'h5A, "rd_across_drain");
        expect_at(e + 31, S_GRANT, 0, "grant_at_settle_m1");
        expect_at(e + 31, S_PAUSE, 1, "pause_hold");
        expect_at(e + 32, S_GRANT, 1, "grant_at_settle");
        step();
        cpu_ce = 1'b0; cpu_sel = 1'b0;
        while (cyc < e + 32) step();

        // Hiscore burst writes, a conflicting CPU strobe, then reads.
        g = cyc;
        hs_write = 1'b1; hs_address = 11'h700; hs_data_in = 8'h11; push_write(11'h700, 8'h11);
        step();
        hs_address = 11'h701; hs_data_in = 8'h22; push_write(11'h701, 8'h22);
        step();
        hs_address = 11'h702; hs_data_in = 8'h33; push_write(11'h702, 8'h33);
        step();
        hs_write = 1'b0; hs_address = 11'h701;
        cpu_ce = 1'b1; cpu_sel = 1'b1; cpu_wr = 1'b1; cpu_ad = 11'h050; cpu_wd = 8'hEE;
        expect_at(g + 4,  S_CONF, 1, "conflict_set");
        expect_at(g + 6,  S_HSDO, 32'h22, "hs_rd_701");
        expect_at(g + 7,  S_HSDO, 32'h11, "hs_rd_700");
        expect_at(g + 8,  S_HSDO, 32'h33, "hs_rd_702");
        expect_at(g + 9,  S_HSDO, 32'h00, "hs_rd_050_untouched");
        expect_at(g + 12, S_CONF, 1, "conflict_sticky");
        step();
        cpu_ce = 1'b0; cpu_sel = 1'b0; cpu_wr = 1'b0;
        hs_address = 11'h700;
        step();
        hs_address = 11'h702;
        step();
        hs_address = 11'h050;
        repeat (4) step();

        // Release.
        hs_access = 1'b0;
        r = cyc + 1;
        expect_at(r,     S_GRANT, 0, "release_grant_fall");
        expect_at(r,     S_PAUSE, 1, "release_pause_hold");
        expect_at(r,     S_WE,    0, "release_we");
        expect_at(r + 1, S_PAUSE, 0, "release_pause_fall");
        expect_at(r + 3, S_CONF,  1, "conflict_after_release");
        repeat (3) step();
        cpu_access(1'b1, 1'b0, 11'h701, 8'h00, 8'h22);

        // Abort during DRAIN.
        hs_access = 1'b1;
        a = cyc + 1;
        expect_at(a,     S_PAUSE, 1, "abort_pause_rise");
        expect_at(a + 5, S_PAUSE, 1, "abort_pause_hold");
        expect_at(a + 6, S_PAUSE, 0, "abort_pause_fall");
        for (int j = 0; j <= 40; j += 5) expect_at(a + j, S_GRANT, 0, "abort_no_grant");
        repeat (5) step();
        hs_access = 1'b0;
        repeat (3) step();
        cpu_access(1'b1, 1'b1, 11'h055, 8'h77, 8'h00);
        cpu_access(1'b1, 1'b0, 11'h055, 8'h00, 8'h77);
        repeat (10) step();

        // Reset in the middle of a hiscore write burst.
        hs_access = 1'b1;
        e = cyc + 1;
        expect_at(e + 32, S_GRANT, 1, "regrant");
        step();
        while (cyc < e + 32) step();
        w = cyc + 1;
        hs_write = 1'b1; hs_address = 11'h100; hs_data_in = 8'h99; push_write(11'h100, 8'h99);
        expect_at(w, S_CONF, 1, "conflict_before_reset");
        step();
        hs_address = 11'h101; hs_data_in = 8'h98; push_write(11'h101, 8'h98);
        step();
        #2 reset = 1'b1;
        #1;
        check("async_rst_pause", 32'(pause_req), 0);
        check("async_rst_grant", 32'(hs_grant), 0);
        check("async_rst_we",    32'(ram_we), 0);
        check("async_rst_conf",  32'(conflict), 0);
        step();
        step();
        hs_access = 1'b0; hs_write = 1'b0; hs_address = '0; hs_data_in = '0;
        reset = 1'b0;
        k = cyc + 1;
        expect_at(k, S_PAUSE, 0, "post_rst_pause");
        expect_at(k, S_GRANT, 0, "post_rst_grant");
        expect_at(k, S_CONF,  0, "post_rst_conflict");
        expect_at(k, S_CPURD, 0, "post_rst_cpu_rd");
        expect_at(k, S_HSDO,  0, "post_rst_hs_do");
        step();
        cpu_access(1'b1, 1'b1, 11'h0AA, 8'h3C, 8'h00);
        cpu_access(1'b1, 1'b0, 11'h0AA, 8'h00, 8'h3C);
        cpu_access(1'b1, 1'b0, 11'h100, 8'h00, 8'h99);
        cpu_access(1'b1, 1'b0, 11'h101, 8'h00, 8'h00);

        repeat (5) step();
        foreach (chkq[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unserved_%s: got no sample at cyc %0d, required a check", chkq[i].name, chkq[i].cyc);
        end
        foreach (wq[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_ram_write: got none, required ad=%0h wd=%0h", wq[i].ad, wq[i].wd);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
